// File: rtl/led_matrix_pwm_if.sv
// Host-side bus of the LED matrix driver: pixel writes, swap handshake and the scanned pin outputs.
interface led_matrix_pwm_if #(
  parameter int DIM_X = 6,
  parameter int DIM_Y = 6,
  parameter int BPP   = 4
);
  localparam int NPIX = DIM_X * DIM_Y;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [BPP-1:0]   wr_data;
  logic             swap_req;
  logic             swap_busy;
  logic             frame_sync;
  logic [DIM_Y-1:0] row;
  logic [DIM_X-1:0] col;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req,
    input  swap_busy, frame_sync, row, col
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req,
    output swap_busy, frame_sync, row, col
  );
endinterface

// File: rtl/led_matrix_pwm.sv
// Row-scanned LED matrix PWM driver with a double-buffered frame store; swaps land only on frame boundaries.
// Optional dead time between rows is enabled by defining LED_MATRIX_BLANK_EN.
module led_matrix_pwm #(
  parameter int DIM_X          = 6,
  parameter int DIM_Y          = 6,
  parameter int BPP            = 4,
  parameter int SLOT_DIV       = 16,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int BLANK_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  led_matrix_pwm_if.slave bus
);
  localparam int NPIX = DIM_X * DIM_Y;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DW   = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
  localparam int RW   = (DIM_Y > 1) ? $clog2(DIM_Y) : 1;
  localparam logic [DW-1:0]    DIV_MAX  = DW'(SLOT_DIV - 1);
  localparam logic [BPP-1:0]   SLOT_MAX = BPP'((1 << BPP) - 2);
  localparam logic [RW-1:0]    ROW_MAX  = RW'(DIM_Y - 1);
  localparam logic [AW:0]      NPIX_W   = (AW+1)'(NPIX);
  localparam logic [DIM_X-1:0] COL_OFF  = {DIM_X{COL_ACTIVE_LOW != 0}};

  logic [DW-1:0]    div;
  logic [BPP-1:0]   slot;
  logic [RW-1:0]    row_cnt;
  logic [RW-1:0]    row_next;
  logic             front_sel;
  logic             swap_busy;
  logic             frame_sync;
  logic [DIM_Y-1:0] row_q;
  logic [DIM_X-1:0] col_q;
  logic [BPP-1:0]   fb [2][NPIX];
  logic [AW-1:0]    base;
  logic [DIM_X-1:0] lit;
  logic             scanning;
  logic             div_end;
  logic             slot_end;
  logic             frame_end;
  logic             wr_ok;
  logic             swap_now;

`ifdef LED_MATRIX_BLANK_EN
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic {SCAN, BLANK} state_t;
  state_t        state;
  logic [BW-1:0] bcnt;

  assign scanning = (state == SCAN);
`else
  assign scanning = 1'b1;
`endif

  assign div_end   = (div == DIV_MAX);
  assign slot_end  = (slot == SLOT_MAX);
  assign frame_end = scanning && div_end && slot_end && (row_cnt == ROW_MAX);
  assign row_next  = (row_cnt == ROW_MAX) ? '0 : row_cnt + RW'(1);
  assign wr_ok     = bus.wr_en && ({1'b0, bus.wr_addr} < NPIX_W);
  assign swap_now  = frame_end && (swap_busy || bus.swap_req);

  // A pixel is lit while its brightness exceeds the current slot index.
  always_comb begin
    base = AW'(row_cnt * DIM_X);
    lit  = '0;
    for (int x = 0; x < DIM_X; x++) begin
      lit[x] = fb[front_sel][base + AW'(x)] > slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      slot       <= '0;
      row_cnt    <= '0;
      front_sel  <= 1'b0;
      swap_busy  <= 1'b0;
      frame_sync <= 1'b0;
      row_q      <= '0;
      col_q      <= COL_OFF;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NPIX; i++) begin
          fb[b][i] <= '0;
        end
      end
`ifdef LED_MATRIX_BLANK_EN
      state <= SCAN;
      bcnt  <= '0;
`endif
    end else begin
      // Writing the back buffer on the swap cycle makes the pixel part of the new front.
      if (wr_ok) begin
        fb[~front_sel][bus.wr_addr] <= bus.wr_data;
      end
      if (swap_now) begin
        front_sel <= ~front_sel;
        swap_busy <= 1'b0;
      end else if (bus.swap_req) begin
        swap_busy <= 1'b1;
      end

      frame_sync <= scanning && (div == '0) && (slot == '0) && (row_cnt == '0);
      if (scanning) begin
        row_q <= DIM_Y'(1) << row_cnt;
        col_q <= (COL_ACTIVE_LOW != 0) ? ~lit : lit;
      end else begin
        row_q <= '0;
        col_q <= COL_OFF;
      end

`ifdef LED_MATRIX_BLANK_EN
      case (state)
        SCAN: begin
          if (div_end) begin
            div <= '0;
            if (slot_end) begin
              slot  <= '0;
              bcnt  <= '0;
              state <= BLANK;
            end else begin
              slot <= slot + BPP'(1);
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        BLANK: begin
          if (bcnt == BLANK_LAST) begin
            state   <= SCAN;
            row_cnt <= row_next;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: state <= SCAN;
      endcase
`else
      if (div_end) begin
        div <= '0;
        if (slot_end) begin
          slot    <= '0;
          row_cnt <= row_next;
        end else begin
          slot <= slot + BPP'(1);
        end
      end else begin
        div <= div + DW'(1);
      end
`endif
    end
  end

  assign bus.swap_busy  = swap_busy;
  assign bus.frame_sync = frame_sync;
  assign bus.row        = row_q;
  assign bus.col        = col_q;
endmodule

// File: tb/tb_led_matrix_pwm.sv
// Directed bench for led_matrix_pwm: 6x6/BPP=4 active-low instance plus a BPP=1 active-high instance.
`timescale 1ns/1ps
module tb_led_matrix_pwm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef LED_MATRIX_BLANK_EN
  localparam int BL = 4;
`else
  localparam int BL = 0;
`endif
  localparam int PA = 15 * 2 + BL;  // row period, instance A
  localparam int FA = 6 * PA;       // frame period, instance A
  localparam int PB = 1 * 2 + BL;   // row period, instance B

  led_matrix_pwm_if #(.DIM_X(6), .DIM_Y(6), .BPP(4)) bus_a ();
  led_matrix_pwm_if #(.DIM_X(6), .DIM_Y(6), .BPP(1)) bus_b ();

  led_matrix_pwm #(.DIM_X(6), .DIM_Y(6), .BPP(4), .SLOT_DIV(2), .COL_ACTIVE_LOW(1), .BLANK_CYCLES(4))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  led_matrix_pwm #(.DIM_X(6), .DIM_Y(6), .BPP(1), .SLOT_DIV(2), .COL_ACTIVE_LOW(0), .BLANK_CYCLES(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         r;
    int         s;
    int         d;
    logic [5:0] e_row;
    logic [5:0] e_col;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input bit use_b);
    for (int i = 0; i < 4 * FA; i++) begin
      @(negedge clk);
      if ((use_b ? bus_b.frame_sync : bus_a.frame_sync) === 1'b1) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL frame_sync_timeout: got no pulse, required one within %0d clk", 4 * FA);
  endtask

  task automatic wr_pix(input bit use_b, input int addr, input int data);
    if (use_b) begin
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 6'(addr); bus_b.wr_data = 1'(data);
    end else begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 6'(addr); bus_a.wr_data = 4'(data);
    end
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  task automatic pulse_req(input bit use_b);
    if (use_b) bus_b.swap_req = 1'b1;
    else       bus_a.swap_req = 1'b1;
    @(negedge clk);
    bus_a.swap_req = 1'b0;
    bus_b.swap_req = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int v = 0; v < 8; v++) begin
      wait_fs(1'b0);
      skip(tbl[v].r * PA + tbl[v].s * 2 + tbl[v].d);
      check($sformatf("%s_row_v%0d", tag, v), 32'(bus_a.row), 32'(tbl[v].e_row));
      check($sformatf("%s_col_v%0d", tag, v), 32'(bus_a.col), 32'(tbl[v].e_col));
    end
  endtask

  initial begin
    int cnt;
    // Image: pix0 = 15 (row0/col0), pix7 = 8 (row1/col1); columns active-low.
    tbl[0] = '{0,  0, 0, 6'b000001, 6'b111110};
    tbl[1] = '{0, 14, 1, 6'b000001, 6'b111110};
    tbl[2] = '{1,  0, 0, 6'b000010, 6'b111101};
    tbl[3] = '{1,  7, 1, 6'b000010, 6'b111101};
    tbl[4] = '{1,  8, 0, 6'b000010, 6'b111111};
    tbl[5] = '{1, 14, 1, 6'b000010, 6'b111111};
    tbl[6] = '{2,  0, 0, 6'b000100, 6'b111111};
    tbl[7] = '{5, 14, 1, 6'b100000, 6'b111111};

    rst = 1'b1;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.swap_req = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.swap_req = 1'b0;
    skip(3);
    check("rst_row",   32'(bus_a.row), 32'h0);
    check("rst_col",   32'(bus_a.col), 32'h3f);
    check("rst_busy",  32'(bus_a.swap_busy), 32'h0);
    check("rst_fs",    32'(bus_a.frame_sync), 32'h0);
    check("rst_col_b", 32'(bus_b.col), 32'h0);
    check("rst_row_b", 32'(bus_b.row), 32'h0);

    rst = 1'b0;
    skip(1);
    check("fs_first",     32'(bus_a.frame_sync), 32'h1);
    check("row_first",    32'(bus_a.row), 32'h1);
    skip(1);
    check("fs_one_cycle", 32'(bus_a.frame_sync), 32'h0);

    // Test 1: load image in back buffer, swap at the boundary.
    wr_pix(1'b0, 0, 15);
    wr_pix(1'b0, 7, 8);
    pulse_req(1'b0);
    check("t1_busy_set",  32'(bus_a.swap_busy), 32'h1);
    check("t1_back_hid",  32'(bus_a.col), 32'h3f);
    wait_fs(1'b0);
    check("t1_busy_clr",  32'(bus_a.swap_busy), 32'h0);
    run_table("t1");

    // Test 2: three requests in one frame give exactly one toggle.
    wait_fs(1'b0);
    skip(10);
    pulse_req(1'b0);
    check("t2_busy_k11", 32'(bus_a.swap_busy), 32'h1);
    skip(39);
    pulse_req(1'b0);
    skip(49);
    pulse_req(1'b0);
    skip(5 * PA + 28 - 101);
    check("t2_busy_pre",  32'(bus_a.swap_busy), 32'h1);
    skip(1);
    check("t2_busy_post", 32'(bus_a.swap_busy), 32'h0);
    wait_fs(1'b0);
    check("t2_col_r0", 32'(bus_a.col), 32'h3f);
    skip(PA);
    check("t2_row_r1", 32'(bus_a.row), 32'h2);
    check("t2_col_r1", 32'(bus_a.col), 32'h3f);

    // Test 3: out-of-range writes are dropped; swapping back restores the image.
    wr_pix(1'b0, 36, 15);
    wr_pix(1'b0, 63, 15);
    pulse_req(1'b0);
    run_table("t3");

    // Test 4: reset mid-row 3 with a swap pending.
    wait_fs(1'b0);
    skip(3 * PA + 5);
    pulse_req(1'b0);
    check("t4_busy_pre", 32'(bus_a.swap_busy), 32'h1);
    rst = 1'b1;
    skip(1);
    check("t4_row",  32'(bus_a.row), 32'h0);
    check("t4_col",  32'(bus_a.col), 32'h3f);
    check("t4_busy", 32'(bus_a.swap_busy), 32'h0);
    rst = 1'b0;
    skip(1);
    check("t4_fs", 32'(bus_a.frame_sync), 32'h1);
    pulse_req(1'b0);
    wait_fs(1'b0);
    check("t4_col_r0", 32'(bus_a.col), 32'h3f);
    skip(PA);
    check("t4_col_r1", 32'(bus_a.col), 32'h3f);

    // Test 5: frame period and row-change behaviour.
    wait_fs(1'b0);
    cnt = 0;
    for (int i = 0; i < 2 * FA; i++) begin
      @(negedge clk);
      cnt++;
      if (bus_a.frame_sync === 1'b1) break;
    end
    check("t5_period", 32'(cnt), 32'(FA));
    skip(30);
`ifdef LED_MATRIX_BLANK_EN
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_blank_row_%0d", i), 32'(bus_a.row), 32'h0);
      skip(1);
    end
`endif
    check("t5_row1_start", 32'(bus_a.row), 32'h2);

    // Test 6: BPP=1, active-high columns.
    wr_pix(1'b1, 0, 1);
    wr_pix(1'b1, 9, 1);
    pulse_req(1'b1);
    wait_fs(1'b1);
    check("t6_row_k0", 32'(bus_b.row), 32'h01);
    check("t6_col_k0", 32'(bus_b.col), 32'h01);
    skip(1);
    check("t6_col_k1", 32'(bus_b.col), 32'h01);
    skip(PB - 1);
    check("t6_row_r1",  32'(bus_b.row), 32'h02);
    check("t6_col_r1a", 32'(bus_b.col), 32'h08);
    skip(1);
    check("t6_col_r1b", 32'(bus_b.col), 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, required finish within 5 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
